seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode seven-segment digits.
- Holds a multi-digit hex value and cycles through the digits one at a time.
- Drives the active-low segment bus (bit 7 = dp) and the active-low anode lines.
- Inserts a blanking gap between digits to suppress ghosting.
- Applies new values only on frame boundaries, so the display never shows a torn value.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
PRESCALE, 50000, clk cycles per digit slot (blank + drive)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off; must satisfy 1 <= BLANK_CYCLES < PRESCALE

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  scanning enabled; 0 forces display dark
value  in  4*NUM_DIGITS  hex digits; value[3:0] = digit 0 (rightmost)
dp_mask  in  NUM_DIGITS  decimal point per digit, 1 = lit
lzb  in  1  leading-zero blanking enable
load  in  1  one-cycle pulse: capture value/dp_mask into pending register
load_ack  out  1  one-cycle pulse when pending data is committed to display shadow
seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}
anode_n  out  NUM_DIGITS  active-low digit select, at most one low
frame_start  out  1  one-cycle pulse at start of digit-0 slot

Behaviour:
- Reset values: anode_n all 1, seg_n 8'hFF, load_ack 0, frame_start 0. Shadow, pending and digit index are 0; pending_valid is 0; state is IDLE.
- States:
  - IDLE: anodes off, seg_n FF. Goes to BLANK with idx=0 when enable=1.
  - BLANK: anodes off, seg_n FF. Lasts BLANK_CYCLES, then goes to DRIVE.
  - DRIVE: anode_n[idx]=0, seg_n = pattern of shadow digit idx. Lasts PRESCALE-BLANK_CYCLES, then idx = (idx+1) mod NUM_DIGITS and goes to BLANK.
- Frame period is exactly NUM_DIGITS*PRESCALE cycles. Slot counter width is clog2(PRESCALE).
- enable=0 in any state: IDLE on the next cycle with outputs dark. Re-enable restarts at digit 0 with frame_start.
- Frame boundary is entry into BLANK with idx=0, including the first slot after IDLE:
  - frame_start pulses.
  - If pending_valid: shadow <= pending, pending_valid <= 0, load_ack pulses in the same cycle.
- load: pending <= {value, dp_mask}, pending_valid <= 1. A second load before commit overwrites pending (latest wins) and produces one ack only.
- load coincident with a frame boundary: the commit uses pending as registered before that cycle. The new capture stays pending for the next frame.
- Segment encoding for digits 0-F, active low:
  - C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E
  - Bit 7 is cleared when the digit's dp bit is set.
- Leading-zero blanking, when lzb=1: any digit above the most significant nonzero digit shows 7F-ignoring segments (segments FF-style blank, i.e. bits 6:0 = 1).
  - A blanked digit still occupies its slot and its dp still follows dp_mask.
  - Digit 0 is never blanked, so value 0 shows "0".
- seg_n and anode_n are registered and change in the same cycle; anode low never overlaps a segment-pattern change.
- rst mid-scan: all outputs go to reset values on the next edge. Pending data is lost.

Decomposition:
- Package seg_scan_pkg:
  - SEG_BLANK = 8'hFF
  - hex-to-segment constant table (16 x 8)
  - state enum {IDLE, BLANK, DRIVE}
- One sub-module seg_scan_timer: slot prescaler producing blank_done and slot_done strobes. Cleared by rst or by enable=0.
- FSM, shadow/pending registers and segment lookup stay in the top.

Test Plan (PRESCALE=8, BLANK_CYCLES=2, NUM_DIGITS=4):
1. Reset, then enable=1, load value=16'h12AF, dp_mask=0 -> first frame_start and load_ack in the same cycle.
   - 2 cycles dark, then 6 cycles anode_n=4'b1110 with seg_n=8E.
   - Then digit 1 = 88, digit 2 = A4, digit 3 = F9.
   - Frame repeats every 32 cycles.
2. lzb=1, value=16'h0030, dp_mask=4'b1000 -> digit0 C0, digit1 B0, digit2 FF, digit3 7F (blank with dp).
   - value=0 with lzb=1 -> digit0 C0, digits 1-3 FF.
3. Two loads mid-frame (16'h1111 then 16'h2222) -> display holds old value until the next frame_start.
   - Single load_ack at that boundary; 16'h2222 shown (digit pattern A4).
4. load asserted in the frame_start cycle -> current frame commits the earlier pending data (or none).
   - New value committed and acked exactly 32 cycles later.
5. Drop enable during DRIVE of digit 2 -> next cycle anode_n=F, seg_n=FF.
   - Re-enable -> frame_start on the first cycle of the restarted scan, digit 0 first.
6. Assert rst during DRIVE with a pending load -> outputs at reset values the next cycle.
   - No load_ack after re-enable until a new load; display shows 0000.

Invariant check throughout: popcount(~anode_n) <= 1.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_BLANK : active-low pattern with every segment (and dp) dark
//   SEG_TABLE : active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0-F,
//               indexed by the digit value (entry 0 is the least significant byte)
//   state_e   : scan FSM states
package seg_scan_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DRIVE
  } state_e;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler for the scan controller. Counts 0..PRESCALE-1 inside each
// digit slot and flags the last blank cycle and the last slot cycle.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   clear      : hold the counter at zero (scanning stopped or about to start)
//   blank_done : high on the final cycle of the blanking gap
//   slot_done  : high on the final cycle of the slot
module seg_scan_timer #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic blank_done,
  output logic slot_done
);

  localparam int CNT_W = $clog2(PRESCALE);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign blank_done = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  assign slot_done  = (cnt_q == CNT_W'(PRESCALE - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || slot_done) cnt_d = '0;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode seven-segment digits.
// Each digit slot is a blanking gap (all anodes off) followed by the drive
// phase of one digit. New values are staged in a pending register and only
// copied into the display shadow at a frame boundary (entry into the blank
// phase of digit 0), so a frame never mixes old and new digits.
//   clk         : system clock
//   rst         : synchronous active-high reset
//   enable      : scanning enabled; low forces the display dark
//   value       : hex digits, value[3:0] is digit 0 (rightmost)
//   dp_mask     : decimal point per digit, 1 = lit
//   lzb         : leading-zero blanking enable
//   load        : capture value/dp_mask into the pending register
//   load_ack    : pulse when pending data is committed to the shadow
//   seg_n       : active-low segments {dp,g,f,e,d,c,b,a}
//   anode_n     : active-low digit select, at most one low
//   frame_start : pulse on the first cycle of the digit-0 slot
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    lzb,
  input  logic                    load,
  output logic                    load_ack,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_start
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int VAL_W = 4 * NUM_DIGITS;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VAL_W-1:0]        shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [VAL_W-1:0]        pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [7:0]              seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0]   anode_n_q, anode_n_d;
  logic                    frame_start_q, frame_start_d;
  logic                    load_ack_q, load_ack_d;

  logic                    frame_boundary;
  logic                    commit;
  logic                    lz_blank;
  logic [3:0]              nibble;
  logic                    blank_done;
  logic                    slot_done;

  // Counter restarts from zero on the first blank cycle after IDLE.
  seg_scan_timer #(
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (!enable || (state_q == IDLE)),
    .blank_done (blank_done),
    .slot_done  (slot_done)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    frame_boundary = 1'b0;

    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d        = BLANK;
          idx_d          = '0;
          frame_boundary = 1'b1;
        end
        BLANK: begin
          if (blank_done) state_d = DRIVE;
        end
        DRIVE: begin
          if (slot_done) begin
            state_d = BLANK;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d          = '0;
              frame_boundary = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Commit uses pending as it stood before this edge; a coincident load
    // refills pending and waits for the next frame.
    commit       = frame_boundary && pend_valid_q;
    shadow_val_d = commit ? pend_val_q : shadow_val_q;
    shadow_dp_d  = commit ? pend_dp_q  : shadow_dp_q;
    pend_val_d   = load ? value   : pend_val_q;
    pend_dp_d    = load ? dp_mask : pend_dp_q;
    pend_valid_d = load ? 1'b1 : (commit ? 1'b0 : pend_valid_q);

    frame_start_d = frame_boundary;
    load_ack_d    = commit;

    // DRIVE is never entered on a commit edge, so the current shadow is the
    // one being displayed. A digit is a leading zero when it and every digit
    // above it are zero; digit 0 is always shown.
    nibble   = shadow_val_q[{idx_d, 2'b00} +: 4];
    lz_blank = lzb && (idx_d != '0) && ((shadow_val_q >> {idx_d, 2'b00}) == '0);

    seg_n_d   = SEG_BLANK;
    anode_n_d = '1;
    if (state_d == DRIVE) begin
      anode_n_d = ~(NUM_DIGITS'(1) << idx_d);
      seg_n_d   = lz_blank ? SEG_BLANK : SEG_TABLE[nibble];
      if (shadow_dp_q[idx_d]) seg_n_d[7] = 1'b0;
    end
  end

  // NOTE: shadow and pending are plain registers, not a memory, so they are
  // cleared by reset along with the rest; a reset drops any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      shadow_val_q  <= '0;
      shadow_dp_q   <= '0;
      pend_val_q    <= '0;
      pend_dp_q     <= '0;
      pend_valid_q  <= 1'b0;
      seg_n_q       <= SEG_BLANK;
      anode_n_q     <= '1;
      frame_start_q <= 1'b0;
      load_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_val_q  <= shadow_val_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_val_q    <= pend_val_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      seg_n_q       <= seg_n_d;
      anode_n_q     <= anode_n_d;
      frame_start_q <= frame_start_d;
      load_ack_q    <= load_ack_d;
    end
  end

  assign seg_n       = seg_n_q;
  assign anode_n     = anode_n_q;
  assign frame_start = frame_start_q;
  assign load_ack    = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (4 digits, 8-cycle slots, 2 blank).
// A reference model tracks the scan as a cycle position within the frame and
// derives the expected outputs from that position every cycle.
module tb_seg_scan_ctrl;

  localparam int NUM_DIGITS   = 4;
  localparam int PRESCALE     = 8;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = NUM_DIGITS * PRESCALE;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        lzb;
  logic        load;
  logic        load_ack;
  logic [7:0]  seg_n;
  logic [3:0]  anode_n;
  logic        frame_start;

  seg_scan_ctrl #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .value       (value),
    .dp_mask     (dp_mask),
    .lzb         (lzb),
    .load        (load),
    .load_ack    (load_ack),
    .seg_n       (seg_n),
    .anode_n     (anode_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int dut_acks = 0;

  // Reference model state
  bit          running = 0;
  int          t       = 0;
  logic [15:0] m_shadow = '0;
  logic [3:0]  m_sdp    = '0;
  logic [15:0] m_pend   = '0;
  logic [3:0]  m_pdp    = '0;
  bit          m_pv     = 0;
  logic [7:0]  e_seg;
  logic [3:0]  e_an;
  logic        e_fs;
  logic        e_ack;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_pattern(input logic [15:0] v, input logic [3:0] dp,
                                             input int d, input logic lz);
    int msd = 0;
    logic [7:0] s;
    logic [3:0] nib;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != 4'h0) msd = i;
    nib = v[4*d +: 4];
    s   = (lz && d > msd) ? 8'hFF : HEX_SEG[nib];
    if (dp[d]) s[7] = 1'b0;
    return s;
  endfunction

  task automatic model_edge();
    bit boundary = 0;
    int digit;
    e_fs  = 1'b0;
    e_ack = 1'b0;
    if (rst) begin
      running = 0; t = 0;
      m_shadow = '0; m_sdp = '0; m_pend = '0; m_pdp = '0; m_pv = 0;
    end else begin
      if (!enable) begin
        running = 0;
      end else if (!running) begin
        running = 1; t = 0; boundary = 1;
      end else begin
        t = (t + 1) % FRAME;
        boundary = (t == 0);
      end
      if (boundary) begin
        e_fs = 1'b1;
        if (m_pv) begin
          m_shadow = m_pend; m_sdp = m_pdp; m_pv = 0; e_ack = 1'b1;
        end
      end
      if (load) begin
        m_pend = value; m_pdp = dp_mask; m_pv = 1;
      end
    end
    if (running && (t % PRESCALE) >= BLANK_CYCLES) begin
      digit = t / PRESCALE;
      e_an  = ~(4'b0001 << digit);
      e_seg = exp_pattern(m_shadow, m_sdp, digit, lzb);
    end else begin
      e_an  = 4'hF;
      e_seg = 8'hFF;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (load_ack === 1'b1) dut_acks++;
    check("seg", seg_n, e_seg);
    check("anode", anode_n, e_an);
    check("frame_start", frame_start, e_fs);
    check("load_ack", load_ack, e_ack);
    check("one_anode", 32'($countones(~anode_n) <= 1), 32'd1);
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value = v; dp_mask = dp; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_anode(input logic [3:0] target, input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (anode_n === target) begin ok = 1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_fs(input string tag);
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (frame_start === 1'b1) begin ok = 1; break; end
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    int acks0;
    logic [15:0] msk;

    rst = 1'b1; enable = 1'b0; value = '0; dp_mask = '0; lzb = 1'b0; load = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    check("rst_seg", seg_n, 8'hFF);
    check("rst_anode", anode_n, 4'hF);
    check("rst_fs", frame_start, 1'b0);
    check("rst_ack", load_ack, 1'b0);

    // 1: first frame commits and acks in the frame_start cycle
    pulse_load(16'h12AF, 4'b0000);
    enable = 1'b1;
    step();
    check("t1_fs", frame_start, 1'b1);
    check("t1_ack", load_ack, 1'b1);
    step();
    check("t1_dark", anode_n, 4'hF);
    step();
    check("t1_anode0", anode_n, 4'b1110);
    check("t1_seg0", seg_n, 8'h8E);
    wait_fs("t1_wait_fs");
    n = 0;
    for (int i = 0; i < 100; i++) begin
      step(); n++;
      if (frame_start === 1'b1) break;
    end
    check("t1_period", n, FRAME);

    // 2: leading-zero blanking
    lzb = 1'b1;
    pulse_load(16'h0030, 4'b1000);
    repeat (70) step();
    pulse_load(16'h0000, 4'b0000);
    repeat (70) step();

    // 3: two loads mid-frame, latest wins, single ack
    wait_anode(4'b1110, "t3_wait");
    acks0 = dut_acks;
    pulse_load(16'h1111, 4'b0000);
    repeat (3) step();
    pulse_load(16'h2222, 4'b0000);
    wait_fs("t3_wait_fs");
    repeat (FRAME) step();
    check("t3_acks", dut_acks - acks0, 1);

    // 4: load in the frame_start cycle is committed one frame later
    wait_fs("t4_wait_fs");
    pulse_load(16'h4567, 4'b0101);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      step(); n++;
      if (load_ack === 1'b1) break;
    end
    check("t4_ack_delay", n, FRAME);

    // 5: drop enable while driving digit 2, then restart
    lzb = 1'b0;
    wait_anode(4'b1011, "t5_wait");
    enable = 1'b0;
    step();
    check("t5_anode_off", anode_n, 4'hF);
    check("t5_seg_off", seg_n, 8'hFF);
    step();
    enable = 1'b1;
    step();
    check("t5_restart_fs", frame_start, 1'b1);
    step(); step();
    check("t5_restart_digit0", anode_n, 4'b1110);

    // 6: reset mid-drive drops the pending load
    wait_anode(4'b1101, "t6_wait");
    pulse_load(16'h9999, 4'b1111);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_seg", seg_n, 8'hFF);
    check("t6_rst_anode", anode_n, 4'hF);
    check("t6_rst_ack", load_ack, 1'b0);
    acks0 = dut_acks;
    repeat (100) step();
    check("t6_no_ack", dut_acks - acks0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 99) < 2) enable = ~enable;
      if ($urandom_range(0, 49) == 0) lzb = ~lzb;
      load = ($urandom_range(0, 19) == 0);
      if (load) begin
        case ($urandom_range(0, 3))
          0: msk = 16'hFFFF;
          1: msk = 16'h0FFF;
          2: msk = 16'h00FF;
          default: msk = 16'h000F;
        endcase
        value   = 16'($urandom) & msk;
        dp_mask = 4'($urandom);
      end
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
